// File: rtl/zktc_mem_pkg.sv
// zktc_mem_pkg: shared types and constants for the memory responder.
package zktc_mem_pkg;
    typedef logic [1:0] wstrb_t;
    localparam wstrb_t WSTRB_READ = 2'b00;
    localparam logic [15:0] ILL_INST = 16'hFF00;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} mem_state_e;
endpackage

// File: rtl/mem_array.sv
// mem_array: two 8-bit byte lanes with per-lane synchronous write and synchronous read.
module mem_array #(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic                  re,
    input  logic [1:0]            we,
    input  logic [15:0]           wdata,
    output logic [15:0]           rdata
);
    logic [7:0]  lo_mem [2**DEPTH_LOG2];
    logic [7:0]  hi_mem [2**DEPTH_LOG2];
    logic [15:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we[0]) lo_mem[addr] <= wdata[7:0];
        if (we[1]) hi_mem[addr] <= wdata[15:8];
        if (re) rdata_q <= {hi_mem[addr], lo_mem[addr]};
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/mem_responder.sv
// mem_responder: valid/ready memory endpoint with configurable wait states.
// Define MEM_UNMAPPED_ILL_EN to trap out-of-range accesses instead of wrapping.
module mem_responder
    import zktc_mem_pkg::*;
#(
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    input  logic [15:0] mem_addr,
    input  logic [15:0] mem_wdata,
    input  logic [1:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [15:0] mem_rdata
);
    mem_state_e            state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [DEPTH_LOG2-1:0] idx_q, idx_d, cur_idx;
    logic                  oob_q, oob_d, cur_oob, in_oob;
    logic [15:0]           wdata_q, wdata_d, cur_wdata;
    wstrb_t                wstrb_q, wstrb_d, cur_wstrb;
    logic [15:0]           rdata_q, rdata_d;
    logic [15:0]           arr_rdata;
    logic                  accept, go_resp, rd_resp, addr_unused;

`ifdef MEM_UNMAPPED_ILL_EN
    assign in_oob = |mem_addr[15:DEPTH_LOG2+1];
`else
    assign in_oob = 1'b0;
`endif
    assign addr_unused = ^{mem_addr[15:DEPTH_LOG2+1], mem_addr[0]};

    assign accept    = (state_q == IDLE) && mem_valid;
    assign cur_idx   = accept ? mem_addr[DEPTH_LOG2:1] : idx_q;
    assign cur_oob   = accept ? in_oob : oob_q;
    assign cur_wdata = accept ? mem_wdata : wdata_q;
    assign cur_wstrb = accept ? mem_wstrb : wstrb_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        oob_d   = oob_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        if (accept) begin
            idx_d   = mem_addr[DEPTH_LOG2:1];
            oob_d   = in_oob;
            wdata_d = mem_wdata;
            wstrb_d = mem_wstrb;
            cnt_d   = 4'(WAIT_CYCLES - 1);
            state_d = (WAIT_CYCLES > 0) ? WAIT : RESP;
        end else if (state_q == WAIT) begin
            state_d = (cnt_q == 4'd0) ? RESP : WAIT;
            cnt_d   = (cnt_q == 4'd0) ? cnt_q : cnt_q - 4'd1;
        end else if (state_q == RESP) begin
            state_d = IDLE;
        end
    end

    // RAM is touched only on the edge entering RESP; reset gates it so an aborted write never lands
    assign go_resp = (state_d == RESP) && (state_q != RESP) && !rst;
    assign rd_resp = (state_q == RESP) && (wstrb_q == WSTRB_READ);
    assign mem_ready = (state_q == RESP);
    assign mem_rdata = rd_resp ? (oob_q ? ILL_INST : arr_rdata) : rdata_q;
    assign rdata_d   = mem_rdata;

    mem_array #(.DEPTH_LOG2(DEPTH_LOG2)) u_array (
        .clk   (clk),
        .addr  (cur_idx),
        .re    (go_resp && (cur_wstrb == WSTRB_READ)),
        .we    ((go_resp && !cur_oob) ? cur_wstrb : 2'b00),
        .wdata (cur_wdata),
        .rdata (arr_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            oob_q   <= 1'b0;
            wdata_q <= '0;
            wstrb_q <= WSTRB_READ;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            oob_q   <= oob_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            rdata_q <= rdata_d;
        end
    end
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: scoreboard bench over three responders with 0, 2 and 3 wait states.
module tb_mem_responder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid [3];
    logic [15:0] addr  [3];
    logic [15:0] wdata [3];
    logic [1:0]  wstrb [3];
    logic        ready [3];
    logic [15:0] rdata [3];
    logic [15:0] last  [3];
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;

    typedef struct {
        int          d;
        int          cyc;
        logic [15:0] data;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_responder #(.DEPTH_LOG2(10), .WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .rst(rst), .mem_valid(valid[0]), .mem_addr(addr[0]), .mem_wdata(wdata[0]),
        .mem_wstrb(wstrb[0]), .mem_ready(ready[0]), .mem_rdata(rdata[0]));
    mem_responder #(.DEPTH_LOG2(10), .WAIT_CYCLES(2)) u_w2 (
        .clk(clk), .rst(rst), .mem_valid(valid[1]), .mem_addr(addr[1]), .mem_wdata(wdata[1]),
        .mem_wstrb(wstrb[1]), .mem_ready(ready[1]), .mem_rdata(rdata[1]));
    mem_responder #(.DEPTH_LOG2(10), .WAIT_CYCLES(3)) u_w3 (
        .clk(clk), .rst(rst), .mem_valid(valid[2]), .mem_addr(addr[2]), .mem_wdata(wdata[2]),
        .mem_wstrb(wstrb[2]), .mem_ready(ready[2]), .mem_rdata(rdata[2]));

    function automatic int wof(input int d);
        return (d == 0) ? 0 : (d == 1) ? 2 : 3;
    endfunction

    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (ready[d]) begin
                total++;
                if (sb.size() == 0 || sb[0].d != d) begin
                    bad++;
                    $display("FAIL unexpected_ready dut%0d cyc=%0d got ready=1 required=0", d, cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (cyc != e.cyc) begin
                        bad++;
                        $display("FAIL latency dut%0d ready at cyc=%0d required cyc=%0d", d, cyc, e.cyc);
                    end
                    total++;
                    if (rdata[d] !== e.data) begin
                        bad++;
                        $display("FAIL rdata dut%0d got %h required %h", d, rdata[d], e.data);
                    end
                end
            end
        end
    end

    task automatic drive(input int d, input logic [15:0] a, input logic [15:0] wd, input logic [1:0] ws);
        addr[d]  = a;
        wdata[d] = wd;
        wstrb[d] = ws;
        valid[d] = 1'b1;
    endtask

    task automatic push(input int d, input int at, input logic [1:0] ws, input logic [15:0] rd_exp);
        exp_t e;
        e.d    = d;
        e.cyc  = at;
        e.data = (ws == 2'b00) ? rd_exp : last[d];
        if (ws == 2'b00) last[d] = rd_exp;
        sb.push_back(e);
    endtask

    task automatic wait_ready(input int d);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ready[d]) return;
        end
        total++;
        bad++;
        $display("FAIL timeout dut%0d ready=0 required=1", d);
    endtask

    task automatic xfer(input int d, input logic [15:0] a, input logic [15:0] wd,
                        input logic [1:0] ws, input logic [15:0] rd_exp);
        @(negedge clk);
        drive(d, a, wd, ws);
        push(d, cyc + 1 + wof(d), ws, rd_exp);
        wait_ready(d);
        valid[d] = 1'b0;
    endtask

    task automatic check_reset_state(input int d);
        total++;
        if (ready[d] !== 1'b0 || rdata[d] !== 16'h0000) begin
            bad++;
            $display("FAIL reset_state dut%0d got ready=%b rdata=%h required ready=0 rdata=0000",
                     d, ready[d], rdata[d]);
        end
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            valid[d] = 1'b0;
            addr[d]  = '0;
            wdata[d] = '0;
            wstrb[d] = '0;
            last[d]  = '0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) check_reset_state(d);
        rst = 1'b0;

        xfer(0, 16'h0010, 16'hBEEF, 2'b11, 16'h0);
        xfer(0, 16'h0010, 16'h0, 2'b00, 16'hBEEF);
        xfer(0, 16'h0010, 16'h1234, 2'b01, 16'h0);
        xfer(0, 16'h0010, 16'h0, 2'b00, 16'hBE34);
        xfer(0, 16'h0010, 16'h5600, 2'b10, 16'h0);
        xfer(0, 16'h0010, 16'h0, 2'b00, 16'h5634);

        xfer(0, 16'h0000, 16'h1111, 2'b11, 16'h0);
`ifdef MEM_UNMAPPED_ILL_EN
        xfer(0, 16'h0800, 16'h0, 2'b00, 16'hFF00);
        xfer(0, 16'h0800, 16'h2222, 2'b11, 16'h0);
        xfer(0, 16'h0000, 16'h0, 2'b00, 16'h1111);
`else
        xfer(0, 16'h0800, 16'h0, 2'b00, 16'h1111);
        xfer(0, 16'h0800, 16'h2222, 2'b11, 16'h0);
        xfer(0, 16'h0000, 16'h0, 2'b00, 16'h2222);
`endif

        xfer(2, 16'h0010, 16'hCAFE, 2'b11, 16'h0);
        @(negedge clk);
        drive(2, 16'h0010, 16'h0, 2'b00);
        push(2, cyc + 4, 2'b00, 16'hCAFE);
        push(2, cyc + 9, 2'b00, 16'hCAFE);
        wait_ready(2);
        wait_ready(2);
        valid[2] = 1'b0;

        xfer(2, 16'h0020, 16'hAAAA, 2'b11, 16'h0);
        xfer(2, 16'h0020, 16'h0, 2'b00, 16'hAAAA);
        @(negedge clk);
        drive(2, 16'h0020, 16'h5555, 2'b11);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        valid[2] = 1'b0;
        @(negedge clk);
        check_reset_state(2);
        rst = 1'b0;
        for (int d = 0; d < 3; d++) last[d] = '0;
        repeat (6) @(negedge clk);
        xfer(2, 16'h0020, 16'h0, 2'b00, 16'hAAAA);

        xfer(1, 16'h0030, 16'h7777, 2'b11, 16'h0);
        @(negedge clk);
        drive(1, 16'h0030, 16'h9999, 2'b11);
        push(1, cyc + 3, 2'b11, 16'h0);
        @(negedge clk);
        valid[1] = 1'b0;
        wait_ready(1);
        repeat (6) @(negedge clk);
        xfer(1, 16'h0030, 16'h0, 2'b00, 16'h9999);

        repeat (4) @(negedge clk);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain got %0d pending required 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
